pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, handshaked pipeline stage register. It is the generic successor to the fixed-field inter-stage registers: one instance carries an arbitrary control field and data field between any two pipeline stages. It supports hazard-unit stall (hold) and flush (bubble), valid/ready flow control, an optional skid entry, and a saturating stall-cycle counter. It sits between stage N and stage N+1, with `stall`/`flush` driven by the hazard unit.

## Interface
- `DATA_W`, 32, width of data payload (bus values, immediates, PC values)
- `CTRL_W`, 8, width of control payload (RegWr, MemWr, ALUctr, ...); a bubble zeroes it
- `CLEAR_DATA`, 0, 1 = flush and reset also zero the data field; 0 = data field keeps its stale value
- `CNT_W`, 16, width of the stall counter
- `Clk`  in  1  single clock, rising edge
- `Reset`  in  1  synchronous, active-high
- `stall`  in  1  hazard unit: freeze the stage
- `flush`  in  1  hazard unit: insert bubble, discard contents
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  stage can accept a beat
- `in_ctrl`  in  CTRL_W  upstream control
- `in_data`  in  DATA_W  upstream data
- `out_valid`  out  1  beat presented downstream
- `out_ready`  in  1  downstream accepts
- `out_ctrl`  out  CTRL_W  registered control
- `out_data`  out  DATA_W  registered data
- `occupancy`  out  2  entries held: 0, 1, or 2 (2 only with skid)
- `stall_cnt`  out  CNT_W  cycles the stage was stalled while holding a valid beat

## Operation
- Handshake events:
  - `in_fire` = `in_valid & in_ready`.
  - `out_fire` = `out_valid & out_ready`.
- Priority each cycle: `Reset` > `flush` > `stall` > normal transfer.
- **Reset:**
  - Main and skid entries become invalid.
  - `out_ctrl` = 0.
  - `out_data` = 0 (always cleared on reset, regardless of `CLEAR_DATA`).
  - `stall_cnt` = 0.
  - `in_ready` = 0 while `Reset` is high.
- **Flush:**
  - Both entries become invalid and `out_ctrl` = 0.
  - `out_data` = 0 only if `CLEAR_DATA` = 1.
  - `in_ready` = 0 that cycle; an input beat presented in a flush cycle is dropped.
- **Stall:**
  - All storage holds and `in_ready` = 0.
  - `out_valid` = main_valid & ~`stall`, so no `out_fire` can occur.
  - `stall_cnt` += 1 when main_valid = 1, saturating at all-ones.
- **Normal transfer:**
  - `out_fire` without `in_fire`: the main entry empties, or is refilled from the skid entry.
  - `in_fire`: the beat goes to the main entry if it is empty or being consumed; otherwise it goes to the skid entry.
  - Simultaneous `in_fire` and `out_fire` with the main entry valid: the main entry takes the new beat, with no bubble.
- Ordering is strictly FIFO; no beat is ever duplicated or lost except by flush.
- `out_ctrl`/`out_data` are valid only when `out_valid`; they hold their last values otherwise.

## Timing
- Latency: in → out is 1 cycle. A beat accepted at edge k appears at `out_*` after edge k.
- Throughput: 1 beat/cycle with `out_ready` held at 1.
- `out_valid` depends combinationally on `stall` only. No other combinational in→out path exists.
- After `Reset` deasserts, the first beat can be accepted the same cycle.
- Flush or reset during a stall: flush/reset wins and the stage is empty after the edge.
- `stall_cnt` saturates and never wraps; only `Reset` clears it.

## Configuration
- Macro: `PIPE_STAGE_SKID_EN`.
- **Defined:**
  - The skid entry is present.
  - `in_ready` is registered: `in_ready` = ~skid_valid & ~`stall` & ~`flush` & ~`Reset`.
  - This breaks the `out_ready`→`in_ready` combinational path.
  - `occupancy` can reach 2.
- **Undefined:**
  - No skid entry.
  - `in_ready` = ~`stall` & ~`flush` & ~`Reset` & (~main_valid | `out_ready`), which is combinational.
  - `occupancy` ≤ 1.

## Structure
- Shared package `pipe_pkg`:
  - `RNONE` zero constant.
  - Occupancy encoding constants `OCC_EMPTY` = 0, `OCC_ONE` = 1, `OCC_TWO` = 2.
  - A `stage_cmd` typedef encoding reset/flush/stall/run.
- Sub-module `pipe_stage_slot`: one entry (valid, ctrl, data) with load, clear and hold inputs. It is instantiated once for main, and once more for skid under the macro.

## Test plan
- Reset with `in_valid` = 1 → `out_valid` = 0, `out_ctrl` = 0, `out_data` = 0, `in_ready` = 0, `stall_cnt` = 0.
- Stream data 1..8, `out_ready` = 1 → outputs 1..8 on consecutive cycles, one cycle after each input.
- Beat 0xAA held, `stall` = 1 for 5 cycles, `out_ready` = 1 → `out_valid` = 0 for 5 cycles, then 0xAA emitted once; `stall_cnt` = 5.
- Flush concurrent with `in_valid` (data 0x55, ctrl 0xFF) → next cycle `out_valid` = 0, `out_ctrl` = 0; 0x55 never appears. With `CLEAR_DATA` = 1, `out_data` = 0.
- Skid build (`PIPE_STAGE_SKID_EN`): `out_ready` = 0 while streaming 1,2,3 → 1 and 2 accepted, `in_ready` = 0, `occupancy` = 2. Raising `out_ready` → 1,2,3 in order.
- `CNT_W` = 2 with 6 stalled cycles → `stall_cnt` stops at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for handshaked pipeline stage registers.
// No logic of its own; pipe_stage_reg and pipe_stage_slot import it.
package pipe_pkg;

    localparam int RNONE = 0;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    typedef enum logic [1:0] {
        CMD_RUN   = 2'd0,
        CMD_STALL = 2'd1,
        CMD_FLUSH = 2'd2,
        CMD_RESET = 2'd3
    } stage_cmd;

    // Reset beats flush, and flush beats stall.
    function automatic stage_cmd decode_cmd(input logic reset, input logic flush, input logic stall);
        if (reset)      return CMD_RESET;
        else if (flush) return CMD_FLUSH;
        else if (stall) return CMD_STALL;
        return CMD_RUN;
    endfunction

    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        if (main_v && skid_v)      return OCC_TWO;
        else if (main_v || skid_v) return OCC_ONE;
        return OCC_EMPTY;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One storage entry (valid, ctrl, data) with clear > hold > load priority.
// Latency: loads land one cycle later. No backpressure of its own; the owner decides when to load.
// Loading with load_valid=0 only drops the valid bit, so the payload keeps its last value.
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              clear,
    input  logic              zero_data,
    input  logic              hold,
    input  logic              load,
    input  logic              load_valid,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge Clk) begin
        if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
            if (zero_data)
                data <= '0;
        end else if (!hold && load) begin
            valid <= load_valid;
            if (load_valid) begin
                ctrl <= load_ctrl;
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked stage register with stall/flush, optional skid entry (PIPE_STAGE_SKID_EN) and stall counter.
// Latency: 1 cycle in->out; 1 beat/cycle when out_ready stays high.
// Backpressure: in_ready drops on stall/flush/reset, or when full (skid build: skid entry occupied).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 8,
    parameter bit CLEAR_DATA = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_cmd cmd;
    logic     main_vld;
    logic     skid_vld;
    logic     in_fire;
    logic     out_fire;
    logic     slot_clear;
    logic     slot_hold;
    logic     slot_zero;

    logic              main_load;
    logic              main_load_vld;
    logic [CTRL_W-1:0] main_load_ctrl;
    logic [DATA_W-1:0] main_load_data;

    assign cmd        = decode_cmd(Reset, flush, stall);
    assign slot_clear = (cmd == CMD_RESET) || (cmd == CMD_FLUSH);
    assign slot_hold  = (cmd == CMD_STALL);
    assign slot_zero  = (cmd == CMD_RESET) || CLEAR_DATA;

    assign out_valid = main_vld & ~stall;
    assign out_fire  = out_valid & out_ready;
    assign in_fire   = in_valid & in_ready;
    assign occupancy = occ_count(main_vld, skid_vld);

`ifdef PIPE_STAGE_SKID_EN
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_load;
    logic              skid_load_vld;

    // in_ready looks only at stored state plus hazard inputs, never at out_ready.
    assign in_ready = ~skid_vld & (cmd == CMD_RUN);

    assign main_load      = out_fire | (in_fire & ~main_vld);
    assign main_load_vld  = skid_vld | in_fire;
    assign main_load_ctrl = (out_fire && skid_vld) ? skid_ctrl : in_ctrl;
    assign main_load_data = (out_fire && skid_vld) ? skid_data : in_data;

    assign skid_load_vld = in_fire & main_vld & ~out_fire;
    assign skid_load     = skid_load_vld | (out_fire & skid_vld);

    pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .Clk        (Clk),
        .clear      (slot_clear),
        .zero_data  (slot_zero),
        .hold       (slot_hold),
        .load       (skid_load),
        .load_valid (skid_load_vld),
        .load_ctrl  (in_ctrl),
        .load_data  (in_data),
        .valid      (skid_vld),
        .ctrl       (skid_ctrl),
        .data       (skid_data)
    );
`else
    assign skid_vld = 1'b0;
    assign in_ready = (cmd == CMD_RUN) & (~main_vld | out_ready);

    assign main_load      = in_fire | out_fire;
    assign main_load_vld  = in_fire;
    assign main_load_ctrl = in_ctrl;
    assign main_load_data = in_data;
`endif

    pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .Clk        (Clk),
        .clear      (slot_clear),
        .zero_data  (slot_zero),
        .hold       (slot_hold),
        .load       (main_load),
        .load_valid (main_load_vld),
        .load_ctrl  (main_load_ctrl),
        .load_data  (main_load_data),
        .valid      (main_vld),
        .ctrl       (out_ctrl),
        .data       (out_data)
    );

    // Counts only stalls that freeze a real beat; saturates instead of wrapping.
    always_ff @(posedge Clk) begin
        if (cmd == CMD_RESET)
            stall_cnt <= CNT_W'(RNONE);
        else if (cmd == CMD_STALL && main_vld && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle, plus directed literal checks.
// Two instances share stimulus: defaults, and CLEAR_DATA=1 with a 2-bit stall counter.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        Clk = 1'b0;
    logic        Reset, stall, flush, in_valid, out_ready;
    logic [7:0]  in_ctrl;
    logic [31:0] in_data;

    logic        in_ready, out_valid;
    logic [7:0]  out_ctrl;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        in_ready2, out_valid2;
    logic [7:0]  out_ctrl2;
    logic [31:0] out_data2;
    logic [1:0]  occupancy2;
    logic [1:0]  stall_cnt2;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    logic [39:0] mq[$];
    int          cnt1 = 0;
    int          cnt2 = 0;

    pipe_stage_reg dut (
        .Clk(Clk), .Reset(Reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CLEAR_DATA(1'b1), .CNT_W(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_ctrl(out_ctrl2), .out_data(out_data2),
        .occupancy(occupancy2), .stall_cnt(stall_cnt2)
    );

    initial forever #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Model: a FIFO of at most CAP beats; outputs derive from its size and head.
    always @(negedge Clk) begin
        if (chk_en) begin
            int  n;
            bit  e_ov, e_ir;
            n    = mq.size();
            e_ov = (n > 0) && !stall;
            e_ir = !Reset && !flush && !stall && ((CAP == 2) ? (n < 2) : (n == 0 || out_ready));
            chk("m_out_valid", out_valid, e_ov);
            chk("m_in_ready", in_ready, e_ir);
            chk("m_occupancy", occupancy, n);
            chk("m_stall_cnt", stall_cnt, cnt1);
            chk("m2_out_valid", out_valid2, e_ov);
            chk("m2_in_ready", in_ready2, e_ir);
            chk("m2_occupancy", occupancy2, n);
            chk("m2_stall_cnt", stall_cnt2, cnt2);
            if (e_ov) begin
                chk("m_out_ctrl", out_ctrl, mq[0][39:32]);
                chk("m_out_data", out_data, mq[0][31:0]);
                chk("m2_out_ctrl", out_ctrl2, mq[0][39:32]);
                chk("m2_out_data", out_data2, mq[0][31:0]);
            end
            if (Reset) begin
                mq.delete();
                cnt1 = 0;
                cnt2 = 0;
            end else if (flush) begin
                mq.delete();
            end else if (stall) begin
                if (n > 0) begin
                    cnt1 = (cnt1 < 65535) ? cnt1 + 1 : cnt1;
                    cnt2 = (cnt2 < 3) ? cnt2 + 1 : cnt2;
                end
            end else begin
                if (e_ov && out_ready) void'(mq.pop_front());
                if (in_valid && e_ir) mq.push_back({in_ctrl, in_data});
            end
        end
    end

    initial begin
        int          b;
        int          acc;
        logic [31:0] got[$];

        Reset = 1'b1; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 32'h1234; out_ready = 1'b1;
        step();
        chk_en = 1'b1;
        @(negedge Clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_out_data2", out_data2, 0);
        step();
        Reset = 1'b0;

        for (int i = 1; i <= 9; i++) begin
            in_valid = (i <= 8);
            in_data  = i;
            in_ctrl  = 8'(i);
            @(negedge Clk);
            if (i == 1) chk("first_in_ready", in_ready, 1);
            if (i > 1) begin
                chk("stream_valid", out_valid, 1);
                chk("stream_data", out_data, i - 1);
            end
            step();
        end

        in_valid = 1'b1; in_data = 32'hAA; in_ctrl = 8'h0A;
        step();
        in_valid = 1'b0; stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("stall_out_valid", out_valid, 0);
            step();
        end
        stall = 1'b0;
        @(negedge Clk);
        chk("stall_release_valid", out_valid, 1);
        chk("stall_release_data", out_data, 32'hAA);
        chk("stall_cnt_5", stall_cnt, 5);
        chk("stall_cnt_sat", stall_cnt2, 3);
        step();
        @(negedge Clk);
        chk("stall_emit_once", out_valid, 0);

        in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h11;
        step();
        flush = 1'b1; in_data = 32'h55; in_ctrl = 8'hFF; out_ready = 1'b0;
        @(negedge Clk);
        chk("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge Clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_ctrl", out_ctrl, 0);
        chk("flush_stale_data", out_data, 32'h77);
        chk("flush_clear_data2", out_data2, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge Clk);
            chk("flush_no_55", out_valid, 0);
        end
        step();

        out_ready = 1'b0;
        b = 1;
        in_valid = 1'b1; in_data = 32'(b); in_ctrl = 8'h30;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            acc = int'(in_ready);
            step();
            if (acc != 0) b++;
            in_data = 32'(b);
        end
        @(negedge Clk);
        chk("bp_occupancy", occupancy, CAP);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_accepted", b - 1, CAP);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && got.size() < 3; i++) begin
            in_valid = (b <= 3);
            in_data  = 32'(b);
            @(negedge Clk);
            acc = int'(in_valid && in_ready);
            if (out_valid) got.push_back(out_data);
            step();
            if (acc != 0) b++;
        end
        in_valid = 1'b0;
        chk("bp_count", got.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("bp_order", (i < got.size()) ? got[i] : 32'hFFFF_FFFF, i + 1);

        for (int i = 0; i < 3000; i++) begin
            Reset     = ($urandom_range(99) < 2);
            flush     = ($urandom_range(99) < 5);
            stall     = ($urandom_range(99) < 15);
            in_valid  = ($urandom_range(99) < 70);
            out_ready = ($urandom_range(99) < 70);
            in_ctrl   = 8'($urandom);
            in_data   = $urandom;
            step();
        end
        Reset = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        @(negedge Clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
